jk_bank_driver: RTL and testbench

//  Drives a bank of external JK flip-flops so that the bank settles to a requested target word.
//  Per bit, it encodes each (current q, target) pair into J/K excitation signals.
//  It presents those signals for exactly one clock, then reads the bank back to confirm the result.
//  If the read-back does not match, it retries a bounded number of times.

---
 rtl/jk_drv_pkg.sv | 23 ++
 rtl/jk_excite_enc.sv | 25 ++
 rtl/jk_bank_driver.sv | 99 +++++++++
 tb/tb_jk_bank_driver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared types and constants for the JK bank driver
// FSM state encoding, JK excitation codes {J,K} and the retry counter width helper.
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // clog2(MAX_RETRY+1), floored at 1 bit so MAX_RETRY=0 still yields a legal vector
  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// rtl/jk_excite_enc.sv - combinational per-bit JK excitation encoder
// Set/reset encoding by default; `JK_TOGGLE_PREF_EN makes every changing bit use toggle.
module jk_excite_enc
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_t,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [1:0] w_jk;
`ifdef JK_TOGGLE_PREF_EN
    assign w_jk = (i_q[g] != i_t[g]) ? JK_TGL : JK_HOLD;
`else
    assign w_jk = (i_q[g] == i_t[g]) ? JK_HOLD : (i_t[g] ? JK_SET : JK_RST);
`endif
    assign o_j[g] = w_jk[1];
    assign o_k[g] = w_jk[0];
  end

endmodule

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives an external JK flop bank to a target word with bounded retries
// Encoding style follows jk_excite_enc (`JK_TOGGLE_PREF_EN); FSM timing is identical in both builds.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int            RW    = retry_cnt_w(MAX_RETRY);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_j, r_k, r_target;
  logic [WIDTH-1:0] w_j_nx, w_k_nx, w_target_nx;
  logic [WIDTH-1:0] w_enc_t, w_enc_j, w_enc_k;
  logic [RW-1:0]    r_retry, w_retry_nx;

  // In IDLE the encoder sees the offered word; on retries it sees the latched one
  assign w_enc_t = (r_state == IDLE) ? in_target : r_target;

  jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .i_q (q_in),
    .i_t (w_enc_t),
    .o_j (w_enc_j),
    .o_k (w_enc_k)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_j_nx      = '0;
    w_k_nx      = '0;
    w_target_nx = r_target;
    w_retry_nx  = r_retry;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_target_nx = in_target;
          w_j_nx      = w_enc_j;
          w_k_nx      = w_enc_k;
          w_retry_nx  = '0;
          w_state_nx  = DRIVE;
        end
      end
      DRIVE: w_state_nx = CHECK;
      CHECK: begin
        if (q_in == r_target) begin
          w_state_nx = DONE;
        end else if (r_retry < R_MAX) begin
          w_j_nx     = w_enc_j;
          w_k_nx     = w_enc_k;
          w_retry_nx = r_retry + RW'(1);
          w_state_nx = DRIVE;
        end else begin
          w_state_nx = ERR;
        end
      end
      DONE:    w_state_nx = IDLE;
      ERR:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_j      <= '0;
      r_k      <= '0;
      r_target <= '0;
      r_retry  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_j      <= w_j_nx;
      r_k      <= w_k_nx;
      r_target <= w_target_nx;
      r_retry  <= w_retry_nx;
    end
  end

  assign j_o      = r_j;
  assign k_o      = r_k;
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign error    = (r_state == ERR);

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - directed self-checking bench for jk_bank_driver
// A behavioural 4-bit JK bank on the same clock closes the loop through q_in.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_target;
  logic [3:0] q_in;
  logic [3:0] j_o, k_o;
  logic       busy, done, error;

  logic [3:0] bank;
  logic       bank_load;
  logic [3:0] bank_val;
  logic       force_q0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .q_in      (q_in),
    .j_o       (j_o),
    .k_o       (k_o),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // JK flop truth: 00 hold, 10 set, 01 reset, 11 toggle
  always @(posedge clk) begin
    if (bank_load) bank <= bank_val;
    else           bank <= (j_o & ~bank) | (~k_o & bank);
  end

  assign q_in = force_q0 ? {bank[3:1], 1'b0} : bank;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load_bank(input logic [3:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Offer a target at a negedge; returns at the negedge of cycle 1 after the accept edge
  task automatic offer(input logic [3:0] t);
    in_valid  = 1'b1;
    in_target = t;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_target = '0;
    bank_load = 1'b0;
    bank_val  = '0;
    force_q0  = 1'b0;

    // 1 reset
    repeat (2) @(negedge clk);
    check_eq("rst_j",     j_o,      0);
    check_eq("rst_k",     k_o,      0);
    check_eq("rst_done",  done,     0);
    check_eq("rst_error", error,    0);
    check_eq("rst_busy",  busy,     0);
    check_eq("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // 2 set/reset: 0011 -> 1010
    load_bank(4'b0011);
    offer(4'b1010);
    in_valid = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
    check_eq("sr_drive_j", j_o, 4'b1001);
    check_eq("sr_drive_k", k_o, 4'b1001);
`else
    check_eq("sr_drive_j", j_o, 4'b1000);
    check_eq("sr_drive_k", k_o, 4'b0001);
`endif
    check_eq("sr_busy",  busy,     1);
    check_eq("sr_ready", in_ready, 0);
    @(negedge clk);
    check_eq("sr_check_j",    j_o,  0);
    check_eq("sr_check_k",    k_o,  0);
    check_eq("sr_check_done", done, 0);
    @(negedge clk);
    check_eq("sr_done",  done,  1);
    check_eq("sr_error", error, 0);
    check_eq("sr_bank",  bank,  4'b1010);
    @(negedge clk);
    check_eq("sr_done_clr", done,     0);
    check_eq("sr_idle",     in_ready, 1);

    // 3 no-op: 0110 -> 0110
    load_bank(4'b0110);
    offer(4'b0110);
    in_valid = 1'b0;
    check_eq("nop_j1",   j_o,  0);
    check_eq("nop_k1",   k_o,  0);
    check_eq("nop_busy", busy, 1);
    @(negedge clk);
    check_eq("nop_done2", done, 0);
    @(negedge clk);
    check_eq("nop_done", done, 1);
    check_eq("nop_bank", bank, 4'b0110);
    @(negedge clk);

    // 4 stuck q_in[0]=0, target 0001: three drives then error at cycle 7
    load_bank(4'b0000);
    force_q0 = 1'b1;
    offer(4'b0001);
    in_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 1 || c == 3 || c == 5) begin
        check_eq($sformatf("stk_j0_c%0d", c), j_o[0], 1);
      end else begin
        check_eq($sformatf("stk_j_c%0d", c), j_o, 0);
      end
      check_eq($sformatf("stk_done_c%0d", c), done, 0);
      check_eq($sformatf("stk_err_c%0d", c), error, (c == 7) ? 1 : 0);
      if (c < 7) @(negedge clk);
    end
    @(negedge clk);
    check_eq("stk_err_clr", error,    0);
    check_eq("stk_idle",    in_ready, 1);
    force_q0 = 1'b0;

    // 5 back-pressure: A=0101 accepted, B=1100 held during busy
    load_bank(4'b0000);
    offer(4'b0101);
    in_target = 4'b1100;
    check_eq("bp_ready1", in_ready, 0);
    @(negedge clk);
    check_eq("bp_ready2", in_ready, 0);
    check_eq("bp_j2",     j_o,      0);
    @(negedge clk);
    check_eq("bp_doneA", done,     1);
    check_eq("bp_bankA", bank,     4'b0101);
    check_eq("bp_ready3", in_ready, 0);
    @(negedge clk);
    check_eq("bp_ready4", in_ready, 1);
    check_eq("bp_busy4",  busy,     0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_busyB", busy, 1);
`ifdef JK_TOGGLE_PREF_EN
    check_eq("bp_jB", j_o, 4'b1001);
    check_eq("bp_kB", k_o, 4'b1001);
`else
    check_eq("bp_jB", j_o, 4'b1000);
    check_eq("bp_kB", k_o, 4'b0001);
`endif
    repeat (2) @(negedge clk);
    check_eq("bp_doneB", done, 1);
    check_eq("bp_bankB", bank, 4'b1100);
    @(negedge clk);

    // 6 mid-operation reset during DRIVE
    load_bank(4'b0011);
    offer(4'b1100);
    in_valid = 1'b0;
    check_eq("mr_drive_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_j",     j_o,      0);
    check_eq("mr_k",     k_o,      0);
    check_eq("mr_busy",  busy,     0);
    check_eq("mr_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("mr_done_c%0d", c),  done,  0);
      check_eq($sformatf("mr_error_c%0d", c), error, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
